// File: rtl/vex_cdma_soc.sv
// Copy-engine subsystem: word memory, CDMA engine and a hardwired sequencer that
// fills a source region, DMA-copies it to a destination region and verifies the copy.
module vex_cdma_soc #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] SRC_BASE  = '0,
  parameter logic [ADDR_W-1:0] DST_BASE  = ADDR_W'(8'h80),
  parameter int                LEN       = 64,
  parameter int                FAULT_IDX = -1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [15:0] dma_cycles
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;

  if (LEN < 0 || LEN > 128 ||
      int'(SRC_BASE) + LEN > DEPTH || int'(DST_BASE) + LEN > DEPTH ||
      (int'(SRC_BASE) < int'(DST_BASE) + LEN && int'(DST_BASE) < int'(SRC_BASE) + LEN))
  begin : g_bad_cfg
    $error("vex_cdma_soc: LEN/SRC_BASE/DST_BASE out of range or regions overlap");
  end

  localparam logic [CW-1:0]     LEN_C    = CW'(LEN);
  localparam logic [CW-1:0]     LAST     = CW'(LEN - 1);
  localparam bit                FAULT_EN = (FAULT_IDX >= 0) && (FAULT_IDX < LEN);
  localparam logic [CW-1:0]     FAULT_K  = CW'(FAULT_IDX);
  localparam logic [DATA_W-1:0] PAT_BASE = DATA_W'(32'hC0DE_0000);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_PROG   = 3'd1;
  localparam logic [2:0] S_DWAIT  = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_RD_REQ  = 2'd1;
  localparam logic [1:0] C_RD_DATA = 2'd2;
  localparam logic [1:0] C_WR      = 2'd3;

  logic [2:0]        seq_st;
  logic [CW-1:0]     idx;
  logic              vph;
  logic [1:0]        c_st;
  logic [ADDR_W-1:0] sa, da;
  logic [CW-1:0]     btt, k;
  logic [DATA_W-1:0] wbuf;
  logic              done_pulse;
  logic              start;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] pat;
  logic              mismatch;
  logic [7:0]        err_nxt;
  logic              flt;

  // Reset gates busy so it reads 0 while reset is held, 1 from release until DONE.
  assign busy     = reset && (seq_st != S_DONE);
  assign start    = (seq_st == S_PROG);
  assign pat      = PAT_BASE | DATA_W'(idx);
  assign mismatch = (mem_rdata != pat);
  assign err_nxt  = (mismatch && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  assign flt      = FAULT_EN && (k == FAULT_K);

  // Port ownership follows sequencer state only, so the two masters never collide.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = pat;
    case (seq_st)
      S_INIT: begin
        mem_we   = reset && (LEN != 0);
        mem_addr = SRC_BASE + idx[ADDR_W-1:0];
      end
      S_VERIFY: mem_addr = DST_BASE + idx[ADDR_W-1:0];
      S_DWAIT: begin
        case (c_st)
          C_RD_REQ: mem_addr = sa + k[ADDR_W-1:0];
          C_WR: begin
            mem_addr  = da + k[ADDR_W-1:0];
            mem_we    = reset;
            mem_wdata = wbuf;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Sequencer: done rises on edge 6*LEN+2 after release (edge 3 when LEN = 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_st  <= S_INIT;
      idx     <= '0;
      vph     <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (seq_st)
        S_INIT: begin
          if (LEN == 0 || idx == LAST) begin
            seq_st <= S_PROG;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_PROG: seq_st <= S_DWAIT;
        S_DWAIT: begin
          if (done_pulse) begin
            if (LEN == 0) begin
              seq_st <= S_DONE;
              done   <= 1'b1;
              pass   <= 1'b1;
            end else begin
              seq_st <= S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          if (!vph) begin
            vph <= 1'b1;
          end else begin
            vph     <= 1'b0;
            err_cnt <= err_nxt;
            if (idx == LAST) begin
              seq_st <= S_DONE;
              done   <= 1'b1;
              pass   <= (err_nxt == 8'd0);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE: ;
        default: seq_st <= S_INIT;
      endcase
    end
  end

  // CDMA: three cycles per word (address, capture, write back).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_st       <= C_IDLE;
      sa         <= '0;
      da         <= '0;
      btt        <= '0;
      k          <= '0;
      wbuf       <= '0;
      done_pulse <= 1'b0;
      dma_cycles <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (c_st != C_IDLE) dma_cycles <= dma_cycles + 16'd1;
      case (c_st)
        C_IDLE: begin
          if (start) begin
            sa  <= SRC_BASE;
            da  <= DST_BASE;
            btt <= LEN_C;
            k   <= '0;
            if (LEN_C == '0) done_pulse <= 1'b1;
            else             c_st       <= C_RD_REQ;
          end
        end
        C_RD_REQ:  c_st <= C_RD_DATA;
        C_RD_DATA: begin
          wbuf <= mem_rdata ^ DATA_W'(flt);
          c_st <= C_WR;
        end
        C_WR: begin
          k <= k + 1'b1;
          if (k == btt - 1'b1) begin
            c_st       <= C_IDLE;
            done_pulse <= 1'b1;
          end else begin
            c_st <= C_RD_REQ;
          end
        end
        default: c_st <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vex_cdma_soc.sv
// Directed bench for vex_cdma_soc: default run, fault hook, mid-DMA reset and LEN corners.
`timescale 1ns/1ps
module tb_vex_cdma_soc;

  logic clk;
  logic rst_d, rst_o;

  logic        busy_d, done_d, pass_d;  logic [7:0] err_d;  logic [15:0] dma_d;
  logic        busy_f, done_f, pass_f;  logic [7:0] err_f;  logic [15:0] dma_f;
  logic        busy_1, done_1, pass_1;  logic [7:0] err_1;  logic [15:0] dma_1;
  logic        busy_0, done_0, pass_0;  logic [7:0] err_0;  logic [15:0] dma_0;
  logic        busy_m, done_m, pass_m;  logic [7:0] err_m;  logic [15:0] dma_m;

  int checks = 0;
  int errors = 0;
  int de_d, de_f, de_1, de_0, de_m;
  int l0_writes;

  vex_cdma_soc u_def (.clk(clk), .reset(rst_d), .busy(busy_d), .done(done_d), .pass(pass_d),
                      .err_cnt(err_d), .dma_cycles(dma_d));
  vex_cdma_soc #(.FAULT_IDX(5)) u_flt (.clk(clk), .reset(rst_o), .busy(busy_f), .done(done_f),
                      .pass(pass_f), .err_cnt(err_f), .dma_cycles(dma_f));
  vex_cdma_soc #(.LEN(1)) u_l1 (.clk(clk), .reset(rst_o), .busy(busy_1), .done(done_1),
                      .pass(pass_1), .err_cnt(err_1), .dma_cycles(dma_1));
  vex_cdma_soc #(.LEN(0)) u_l0 (.clk(clk), .reset(rst_o), .busy(busy_0), .done(done_0),
                      .pass(pass_0), .err_cnt(err_0), .dma_cycles(dma_0));
  vex_cdma_soc #(.LEN(128), .DST_BASE(8'h80)) u_l128 (.clk(clk), .reset(rst_o), .busy(busy_m),
                      .done(done_m), .pass(pass_m), .err_cnt(err_m), .dma_cycles(dma_m));

  initial begin
    clk = 1'b0;
    forever #2.5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_d = 1'b0;
    rst_o = 1'b0;
    de_d = 0; de_f = 0; de_1 = 0; de_0 = 0; de_m = 0;
    l0_writes = 0;
    #1;
    check("rst_busy", 32'(busy_d), 32'd0);
    check("rst_done", 32'(done_d), 32'd0);
    check("rst_pass", 32'(pass_d), 32'd0);
    check("rst_err",  32'(err_d),  32'd0);
    check("rst_dma",  32'(dma_d),  32'd0);
    #4;
    rst_d = 1'b1;
    rst_o = 1'b1;

    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        check("busy_edge1", 32'(busy_d), 32'd1);
        check("done_edge1", 32'(done_d), 32'd0);
      end
      if (n == 150) check("dma_edge150", 32'(dma_d), 32'd85);
      if (done_d && de_d == 0) de_d = n;
      if (done_f && de_f == 0) de_f = n;
      if (done_1 && de_1 == 0) de_1 = n;
      if (done_0 && de_0 == 0) de_0 = n;
      if (done_m && de_m == 0) de_m = n;
      if (u_l0.mem_we) l0_writes++;
    end

    check("def_done_edge", 32'(de_d), 32'd386);
    check("def_pass",      32'(pass_d), 32'd1);
    check("def_busy",      32'(busy_d), 32'd0);
    check("def_err",       32'(err_d), 32'd0);
    check("def_dma",       32'(dma_d), 32'd192);
    check("def_mem80",     u_def.mem[8'h80], 32'hC0DE0000);
    check("def_memBF",     u_def.mem[8'hBF], 32'hC0DE003F);

    check("flt_done_edge", 32'(de_f), 32'd386);
    check("flt_pass",      32'(pass_f), 32'd0);
    check("flt_err",       32'(err_f), 32'd1);
    check("flt_mem85",     u_flt.mem[8'h85], 32'hC0DE0004);
    check("flt_mem86",     u_flt.mem[8'h86], 32'hC0DE0006);

    check("l1_done_edge",  32'(de_1), 32'd8);
    check("l1_pass",       32'(pass_1), 32'd1);
    check("l1_dma",        32'(dma_1), 32'd3);
    check("l1_mem80",      u_l1.mem[8'h80], 32'hC0DE0000);

    check("l0_done_edge",  32'(de_0), 32'd3);
    check("l0_pass",       32'(pass_0), 32'd1);
    check("l0_err",        32'(err_0), 32'd0);
    check("l0_dma",        32'(dma_0), 32'd0);
    check("l0_writes",     32'(l0_writes), 32'd0);

    check("l128_done_edge", 32'(de_m), 32'd770);
    check("l128_pass",      32'(pass_m), 32'd1);
    check("l128_dma",       32'(dma_m), 32'd384);
    check("l128_memFF",     u_l128.mem[8'hFF], 32'hC0DE007F);
    check("l128_mem00",     u_l128.mem[8'h00], 32'hC0DE0000);

    // restart the default instance, then hit it with reset in the middle of the copy
    @(negedge clk) rst_d = 1'b0;
    @(negedge clk) rst_d = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(posedge clk); #1;
    end
    check("mid_dma_before", 32'(dma_d), 32'd85);
    @(negedge clk) rst_d = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_d), 32'd0);
    check("mid_rst_done", 32'(done_d), 32'd0);
    check("mid_rst_err",  32'(err_d),  32'd0);
    check("mid_rst_dma",  32'(dma_d),  32'd0);
    @(negedge clk) rst_d = 1'b1;
    de_d = 0;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      if (done_d && de_d == 0) de_d = n;
    end
    check("rerun_done_edge", 32'(de_d), 32'd386);
    check("rerun_pass",      32'(pass_d), 32'd1);
    check("rerun_err",       32'(err_d), 32'd0);
    check("rerun_dma",       32'(dma_d), 32'd192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
